// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into clean pulses of HOLD clocks high followed by
// at least GAP clocks low. Events that arrive while a pulse is in flight are queued.
module pulse_stretcher #(
  parameter int unsigned HOLD = 16,
  parameter int unsigned GAP  = 16,
  parameter int unsigned CW   = 16,
  parameter int unsigned QW   = 4
) (
  input  logic          C,
  input  logic          R,
  input  logic          I,
  input  logic          CLR,
  output logic          O,
  output logic          B,
  output logic [QW-1:0] PEND,
  output logic          OVF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_M1   = CW'(GAP - 1);
  localparam logic [QW-1:0] PEND_MAX = '1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          o_q, o_d;
  logic [QW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;

  logic start_from_i;
  logic start_from_q;
  logic inc;
  logic dec;
  logic ovf_evt;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    o_d          = o_q;
    start_from_i = 1'b0;
    start_from_q = 1'b0;
    case (state_q)
      IDLE: begin
        o_d = 1'b0;
        if (I) begin
          state_d      = HIGH;
          cnt_d        = HOLD_M1;
          o_d          = 1'b1;
          start_from_i = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = LOW;
          cnt_d   = GAP_M1;
          o_d     = 1'b0;
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pend_q != '0 || I) begin
          // A queued event takes priority; a coincident I is then queued behind it.
          state_d      = HIGH;
          cnt_d        = HOLD_M1;
          o_d          = 1'b1;
          start_from_q = (pend_q != '0);
          start_from_i = (pend_q == '0);
        end else begin
          state_d = IDLE;
          o_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        o_d     = 1'b0;
      end
    endcase
  end

  always_comb begin
    inc     = I & ~start_from_i;
    dec     = start_from_q;
    pend_d  = pend_q;
    ovf_evt = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (pend_q == PEND_MAX) ovf_evt = 1'b1;
        else                    pend_d  = pend_q + QW'(1);
      end
      2'b01:   pend_d = pend_q - QW'(1);
      default: pend_d = pend_q;
    endcase
    ovf_d = ovf_evt | (ovf_q & ~CLR);
  end

  assign O    = o_q;
  assign B    = (state_q != IDLE);
  assign PEND = pend_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD=4, GAP=3, QW=2: a vector table of
// per-edge inputs and hand-computed outputs, plus hand sequences for overflow/clear and async reset.
module tb_pulse_stretcher;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       I = 1'b0;
  logic       CLR = 1'b0;
  logic       O;
  logic       B;
  logic [1:0] PEND;
  logic       OVF;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic       i;
    logic       clr;
    logic       o;
    logic       b;
    logic [1:0] p;
    logic       v;
  } vec_t;

  vec_t tbl[$];

  pulse_stretcher #(
    .HOLD(4),
    .GAP (3),
    .CW  (16),
    .QW  (2)
  ) dut (
    .C   (C),
    .R   (R),
    .I   (I),
    .CLR (CLR),
    .O   (O),
    .B   (B),
    .PEND(PEND),
    .OVF (OVF)
  );

  always #5 C = ~C;

  function automatic void add(input logic i, input logic clr, input logic o, input logic b,
                              input logic [1:0] p, input logic v, input int n);
    vec_t e;
    e.i = i; e.clr = clr; e.o = o; e.b = b; e.p = p; e.v = v;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endfunction

  task automatic check(input string name, input logic o, input logic b,
                       input logic [1:0] p, input logic v);
    n_checks++;
    if ({O, B, PEND, OVF} !== {o, b, p, v}) begin
      n_fail++;
      $display("FAIL %s: got O=%b B=%b PEND=%0d OVF=%b, expected O=%b B=%b PEND=%0d OVF=%b",
               name, O, B, PEND, OVF, o, b, p, v);
    end
  endtask

  task automatic step(input string name, input logic i, input logic clr, input logic o,
                      input logic b, input logic [1:0] p, input logic v);
    I   = i;
    CLR = clr;
    @(posedge C);
    #1;
    check(name, o, b, p, v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected $finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    // single event: 4 high, 3 low, then idle
    add(1,0, 1,1,0,0, 1); add(0,0, 1,1,0,0, 3); add(0,0, 0,1,0,0, 3); add(0,0, 0,0,0,0, 2);
    // three consecutive events: period 7, PEND 1,2 then draining
    add(1,0, 1,1,0,0, 1); add(1,0, 1,1,1,0, 1); add(1,0, 1,1,2,0, 1); add(0,0, 1,1,2,0, 1);
    add(0,0, 0,1,2,0, 3); add(0,0, 1,1,1,0, 4); add(0,0, 0,1,1,0, 3);
    add(0,0, 1,1,0,0, 4); add(0,0, 0,1,0,0, 3); add(0,0, 0,0,0,0, 1);
    // gap-end coincidence with PEND=0: back-to-back start, PEND stays 0
    add(1,0, 1,1,0,0, 1); add(0,0, 1,1,0,0, 3); add(0,0, 0,1,0,0, 3);
    add(1,0, 1,1,0,0, 1); add(0,0, 1,1,0,0, 3); add(0,0, 0,1,0,0, 3); add(0,0, 0,0,0,0, 1);
    // gap-end coincidence with PEND=1: start from queue, new I re-queued
    add(1,0, 1,1,0,0, 1); add(1,0, 1,1,1,0, 1); add(0,0, 1,1,1,0, 2); add(0,0, 0,1,1,0, 3);
    add(1,0, 1,1,1,0, 1); add(0,0, 1,1,1,0, 3); add(0,0, 0,1,1,0, 3);
    add(0,0, 1,1,0,0, 4); add(0,0, 0,1,0,0, 3); add(0,0, 0,0,0,0, 1);
    // six events with QW=2: saturate at 3, OVF set, exactly four pulses
    add(1,0, 1,1,0,0, 1); add(1,0, 1,1,1,0, 1); add(1,0, 1,1,2,0, 1); add(1,0, 1,1,3,0, 1);
    add(1,0, 0,1,3,1, 2); add(0,0, 0,1,3,1, 1);
    add(0,0, 1,1,2,1, 4); add(0,0, 0,1,2,1, 3); add(0,0, 1,1,1,1, 4); add(0,0, 0,1,1,1, 3);
    add(0,0, 1,1,0,1, 4); add(0,0, 0,1,0,1, 3); add(0,0, 0,0,0,1, 1);
    // synchronous clear of OVF
    add(0,1, 0,0,0,0, 1); add(0,0, 0,0,0,0, 1);

    #1;
    check("reset_async_assert", 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge C);
    #2;
    R = 1'b0;
    step("reset_idle", 0, 0, 1'b0, 1'b0, 2'd0, 1'b0);

    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k].i, tbl[k].clr, tbl[k].o, tbl[k].b, tbl[k].p, tbl[k].v);

    // CLR coincident with an overflow: overflow wins
    step("ovw_e1", 1, 0, 1'b1, 1'b1, 2'd0, 1'b0);
    step("ovw_e2", 1, 0, 1'b1, 1'b1, 2'd1, 1'b0);
    step("ovw_e3", 1, 0, 1'b1, 1'b1, 2'd2, 1'b0);
    step("ovw_e4", 1, 0, 1'b1, 1'b1, 2'd3, 1'b0);
    step("ovw_clr", 1, 1, 1'b0, 1'b1, 2'd3, 1'b1);
    step("ovw_e6", 0, 0, 1'b0, 1'b1, 2'd3, 1'b1);
    step("ovw_e7", 0, 0, 1'b0, 1'b1, 2'd3, 1'b1);
    step("ovw_e8", 0, 0, 1'b1, 1'b1, 2'd2, 1'b1);
    step("ovw_e9", 0, 0, 1'b1, 1'b1, 2'd2, 1'b1);

    // async reset mid-HIGH with PEND=2, OVF=1, between clock edges
    #2;
    R = 1'b1;
    #1;
    check("rst_mid_pulse", 1'b0, 1'b0, 2'd0, 1'b0);
    step("rst_held", 0, 0, 1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    R = 1'b0;

    step("post_rst_start", 1, 0, 1'b1, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) step("post_rst_high", 0, 0, 1'b1, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) step("post_rst_low", 0, 0, 1'b0, 1'b1, 2'd0, 1'b0);
    step("post_rst_idle", 0, 0, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart to the input conditioning chain of debouncer followed by upedge.
- The input chain turns a noisy level into single-cycle event pulses. This block turns single-cycle event pulses back into clean, slow, human- or off-chip-visible pulses, for LEDs, test points and external handshake lines.
- Each input event produces exactly one output pulse of fixed high width, followed by a guaranteed minimum low gap.
- Events arriving while a pulse is in flight are queued in a saturating counter and replayed back-to-back.

Parameters:
- HOLD, 16: output high time in clocks; must be >= 1.
- GAP, 16: minimum output low time between pulses in clocks; must be >= 1.
- CW, 16: width of the hold/gap counter; must satisfy 2^CW > max(HOLD, GAP) - 1.
- QW, 4: width of the pending-event counter; it saturates at 2^QW - 1.

Ports:
- C  input  1  clock; all state changes on posedge C.
- R  input  1  reset, asynchronous, active-high.
- I  input  1  event input; every clock with I=1 sampled at posedge C is one event.
- CLR  input  1  synchronous clear of OVF.
- O  output  1  stretched pulse output, registered.
- B  output  1  busy; 1 whenever the state is not IDLE.
- PEND  output  QW  number of queued events not yet emitted.
- OVF  output  1  sticky flag: an event was lost because PEND was saturated.

Behaviour:
- Reset: R=1 forces, immediately and without a clock edge, state=IDLE, cnt=0, O=0, PEND=0, OVF=0. This holds mid-pulse as well; the in-flight pulse and the queue are discarded.
- State encoding is internal. The states are IDLE, HIGH and LOW. O is a register that is 1 exactly when the state is HIGH. B = (state != IDLE).
- IDLE:
  - I=1: next state HIGH, cnt <= HOLD-1, O <= 1. Latency is 1: O rises at the same edge that samples I.
  - I=0: stay in IDLE.
  - PEND is always 0 in IDLE.
- HIGH:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: next state LOW, cnt <= GAP-1, O <= 0.
  - O is therefore high for exactly HOLD clocks.
- LOW:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0 and (PEND > 0 or I=1): next state HIGH, cnt <= HOLD-1, O <= 1. One event is consumed, as defined in the queue rules below.
  - cnt == 0 with PEND == 0 and I=0: next state IDLE.
  - O is therefore low for at least GAP clocks. The back-to-back period is HOLD+GAP.
- Queue, evaluated on each posedge C:
  - inc = I=1 and the edge does not start a pulse from this I.
  - dec = the edge starts a pulse from the queue.
  - At the LOW end-of-gap edge with PEND>0 and I=1: both inc and dec apply, so PEND is unchanged.
  - At the LOW end-of-gap edge with PEND=0 and I=1: the pulse starts from I directly and PEND stays 0.
  - In IDLE, I=1 starts a pulse and does not increment PEND.
  - inc only: PEND+1, saturating at 2^QW-1.
  - dec only: PEND-1.
  - Both: PEND unchanged.
- Saturation: inc while PEND = 2^QW-1 (and no dec) keeps PEND at its value and sets OVF <= 1. The event is dropped.
- OVF: sticky. CLR=1 clears it. If CLR=1 and a new overflow occur on the same edge, OVF becomes 1 (overflow wins).
- Arithmetic: PEND and cnt are unsigned. PEND neither wraps nor goes below 0. cnt never decrements past 0.
- I held high for k consecutive clocks counts as k events. I is not edge-detected here; upstream uses upedge for that.

Test Plan:
- Single event, HOLD=4, GAP=3, QW=2: after reset, I=1 for one clock at edge 10 -> O=1 for exactly 4 clocks starting after edge 10. B=1 for 7 clocks, then 0. PEND stays 0.
- Three events on consecutive edges 10, 11, 12 -> PEND reads 1 then 2. Three O pulses, each 4 high / 3 low, period 7. PEND decrements at each pulse start, reaching 0. B drops 7 clocks after the third pulse starts.
- Overflow, QW=2: six events on consecutive edges -> PEND saturates at 3 and OVF=1 after the sixth. Exactly 4 O pulses are emitted. CLR=1 for one clock -> OVF=0. CLR and an overflow on the same edge -> OVF stays 1.
- Gap-end coincidence, case 1: PEND=0, I=1 on the LOW cnt==0 edge -> the next pulse starts on that edge with no extra gap, and PEND stays 0.
- Gap-end coincidence, case 2: PEND=1, I=1 on the same kind of edge -> a new pulse starts and PEND stays 1.
- Async reset: assert R mid-HIGH with PEND=2 and OVF=1, between clock edges -> O, B, PEND and OVF go to 0 immediately. After R is released, one I event yields one normal 4-clock pulse.
